nabp_sinogram_lane_addresser: RTL and testbench

Multi-lane, parametrised sinogram addresser for the NABP back-projection datapath. It sits between the filtered-RAM swap logic and the sinogram RAM. It sweeps projection angles in groups of `NO_OF_LANES` consecutive angles and issues one registered sinogram address per lane from that lane's `s` value. Over the single-lane addresser it adds:
- a start/done sweep handshake, so sweeps can repeat without reset;
- partial last groups;
- `s` mirroring;
- out-of-range `s` flagging.

---
 rtl/nabp_sinogram_lane_addresser.sv | 144 ++++++++++++++
 tb/tb_nabp_sinogram_lane_addresser.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/nabp_sinogram_lane_addresser.sv
// Multi-lane sinogram addresser: sweeps angle groups under start/done, mirrors/flags s per lane.
// Address latency 1 cycle, one word per cycle; no stall path, group advance via combinational ack.
module nabp_sinogram_lane_addresser #(
    parameter int NO_OF_ANGLES = 180,
    parameter int LINE_SIZE    = 256,
    parameter int NO_OF_LANES  = 4,
    parameter int ANGLE_STEP   = 1,
    parameter int S_WIDTH      = 8,
    parameter int ANGLE_WIDTH  = 8,
    parameter int ADDR_WIDTH   = 16
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               start,
    input  logic                               mirror_s,
    input  logic [NO_OF_LANES*S_WIDTH-1:0]     fr_s_val,
    input  logic                               fr_s_valid,
    input  logic                               fr_next_angle,
    output logic [NO_OF_LANES*ANGLE_WIDTH-1:0] fr_angle,
    output logic [NO_OF_LANES-1:0]             fr_lane_en,
    output logic                               fr_has_next_angle,
    output logic                               fr_next_angle_ack,
    output logic                               busy,
    output logic                               done,
    output logic [NO_OF_LANES*ADDR_WIDTH-1:0]  sg_addr,
    output logic                               sg_addr_valid,
    output logic [NO_OF_LANES-1:0]             sg_addr_oob
);

    localparam int KW = $clog2(NO_OF_ANGLES + 2*NO_OF_LANES) + 1;
    localparam logic [KW-1:0]          K_LANES   = KW'(NO_OF_LANES);
    localparam logic [KW-1:0]          K_ANGLES  = KW'(NO_OF_ANGLES);
    localparam logic [ADDR_WIDTH-1:0]  A_GROUP   = ADDR_WIDTH'(NO_OF_LANES*LINE_SIZE);
    localparam logic [ANGLE_WIDTH-1:0] ANG_GROUP = ANGLE_WIDTH'(NO_OF_LANES*ANGLE_STEP);
    localparam logic [ADDR_WIDTH-1:0]  A_LMAX    = ADDR_WIDTH'(LINE_SIZE-1);
    localparam logic [31:0]            S_LIMIT   = 32'(LINE_SIZE);

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t                 r_state;
    // First angle index of the current group, i.e. g*NO_OF_LANES.
    logic [KW-1:0]          r_k0;
    logic [ANGLE_WIDTH-1:0] r_angle [NO_OF_LANES];
    logic [ADDR_WIDTH-1:0]  r_base  [NO_OF_LANES];
    logic                   r_mirror;
    logic                   r_done;
    logic                   r_addr_vld;
    logic [ADDR_WIDTH-1:0]  r_addr  [NO_OF_LANES];
    logic [NO_OF_LANES-1:0] r_oob;

    logic                   w_has_next;
    logic                   w_adv;
    logic                   w_finish;
    logic [NO_OF_LANES-1:0] w_lane_en;
    logic [NO_OF_LANES-1:0] w_oob;
    logic [ADDR_WIDTH-1:0]  w_sp    [NO_OF_LANES];

    assign w_has_next = (r_state == SWEEP) && ((r_k0 + K_LANES) < K_ANGLES);
    assign w_adv      = w_has_next && fr_next_angle;
    assign w_finish   = (r_state == SWEEP) && fr_next_angle && !w_has_next;

    for (genvar l = 0; l < NO_OF_LANES; l++) begin : g_lane
        logic [S_WIDTH-1:0]    w_s;
        logic [ADDR_WIDTH-1:0] w_s_ext;
        assign w_s          = fr_s_val[l*S_WIDTH +: S_WIDTH];
        assign w_s_ext      = ADDR_WIDTH'(w_s);
        assign w_oob[l]     = 32'(w_s) >= S_LIMIT;
        assign w_sp[l]      = r_mirror ? (A_LMAX - w_s_ext) : w_s_ext;
        assign w_lane_en[l] = (r_k0 + KW'(l)) < K_ANGLES;
        assign fr_angle[l*ANGLE_WIDTH +: ANGLE_WIDTH] = r_angle[l];
        assign sg_addr[l*ADDR_WIDTH +: ADDR_WIDTH]    = r_addr[l];
    end

    assign fr_lane_en        = w_lane_en;
    assign fr_has_next_angle = w_has_next;
    assign fr_next_angle_ack = w_adv;
    assign busy              = (r_state == SWEEP);
    assign done              = r_done;
    assign sg_addr_valid     = r_addr_vld;
    assign sg_addr_oob       = r_oob;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_k0       <= '0;
            r_mirror   <= 1'b0;
            r_done     <= 1'b0;
            r_addr_vld <= 1'b0;
            r_oob      <= '0;
            for (int l = 0; l < NO_OF_LANES; l++) begin
                r_angle[l] <= ANGLE_WIDTH'(l*ANGLE_STEP);
                r_base[l]  <= ADDR_WIDTH'(l*LINE_SIZE);
                r_addr[l]  <= '0;
            end
        end else begin
            r_done     <= 1'b0;
            r_addr_vld <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state  <= SWEEP;
                        r_mirror <= mirror_s;
                        r_k0     <= '0;
                        for (int l = 0; l < NO_OF_LANES; l++) begin
                            r_angle[l] <= ANGLE_WIDTH'(l*ANGLE_STEP);
                            r_base[l]  <= ADDR_WIDTH'(l*LINE_SIZE);
                        end
                    end
                end
                SWEEP: begin
                    // Addressing uses this cycle's bases, even if the group advances now.
                    if (fr_s_valid) begin
                        r_addr_vld <= 1'b1;
                        for (int l = 0; l < NO_OF_LANES; l++) begin
                            if (!w_lane_en[l] || w_oob[l]) begin
                                r_addr[l] <= '0;
                            end else begin
                                r_addr[l] <= r_base[l] + w_sp[l];
                            end
                            r_oob[l] <= w_lane_en[l] && w_oob[l];
                        end
                    end
                    if (w_adv) begin
                        r_k0 <= r_k0 + K_LANES;
                        for (int l = 0; l < NO_OF_LANES; l++) begin
                            r_angle[l] <= r_angle[l] + ANG_GROUP;
                            r_base[l]  <= r_base[l] + A_GROUP;
                        end
                    end else if (w_finish) begin
                        r_state <= IDLE;
                        r_done  <= 1'b1;
                        r_k0    <= '0;
                        for (int l = 0; l < NO_OF_LANES; l++) begin
                            r_angle[l] <= ANGLE_WIDTH'(l*ANGLE_STEP);
                            r_base[l]  <= ADDR_WIDTH'(l*LINE_SIZE);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nabp_sinogram_lane_addresser.sv
// Bench for nabp_sinogram_lane_addresser: default instance plus a 182-angle, 9-bit-s instance.
module tb_nabp_sinogram_lane_addresser;

    typedef struct packed {
        logic [63:0] addr;
        logic [3:0]  oob;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset_n;

    logic        a_start, a_mirror, a_sv, a_next;
    logic [31:0] a_s;
    logic [31:0] a_angle;
    logic [3:0]  a_en, a_oob;
    logic        a_has, a_ack, a_busy, a_done, a_avld;
    logic [63:0] a_addr;

    logic        b_start, b_mirror, b_sv, b_next;
    logic [35:0] b_s;
    logic [31:0] b_angle;
    logic [3:0]  b_en, b_oob;
    logic        b_has, b_ack, b_busy, b_done, b_avld;
    logic [63:0] b_addr;

    nabp_sinogram_lane_addresser dut_a (
        .clk(clk), .reset_n(reset_n), .start(a_start), .mirror_s(a_mirror),
        .fr_s_val(a_s), .fr_s_valid(a_sv), .fr_next_angle(a_next),
        .fr_angle(a_angle), .fr_lane_en(a_en), .fr_has_next_angle(a_has),
        .fr_next_angle_ack(a_ack), .busy(a_busy), .done(a_done),
        .sg_addr(a_addr), .sg_addr_valid(a_avld), .sg_addr_oob(a_oob)
    );

    nabp_sinogram_lane_addresser #(.NO_OF_ANGLES(182), .S_WIDTH(9)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(b_start), .mirror_s(b_mirror),
        .fr_s_val(b_s), .fr_s_valid(b_sv), .fr_next_angle(b_next),
        .fr_angle(b_angle), .fr_lane_en(b_en), .fr_has_next_angle(b_has),
        .fr_next_angle_ack(b_ack), .busy(b_busy), .done(b_done),
        .sg_addr(b_addr), .sg_addr_valid(b_avld), .sg_addr_oob(b_oob)
    );

    exp_t qa[$];
    exp_t qb[$];
    int   na = 0;
    int   nf = 0;
    int   a_g, b_g;
    bit   a_mir, b_mir;

    function automatic exp_t model(int n_ang, int g, bit mir, int s0, int s1, int s2, int s3);
        exp_t e;
        int   s[4];
        s = '{s0, s1, s2, s3};
        e = '0;
        for (int l = 0; l < 4; l++) begin
            int k;
            k = g*4 + l;
            if (k < n_ang) begin
                if (s[l] >= 256) e.oob[l] = 1'b1;
                else e.addr[l*16 +: 16] = 16'(k*256 + (mir ? 255 - s[l] : s[l]));
            end
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        na++;
        assert (obs === exp) else begin
            nf++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_a(input int s3, input int s2, input int s1, input int s0);
        a_s  = {8'(s3), 8'(s2), 8'(s1), 8'(s0)};
        a_sv = 1'b1;
        qa.push_back(model(180, a_g, a_mir, s0, s1, s2, s3));
    endtask

    task automatic drive_b(input int s3, input int s2, input int s1, input int s0);
        b_s  = {9'(s3), 9'(s2), 9'(s1), 9'(s0)};
        b_sv = 1'b1;
        qb.push_back(model(182, b_g, b_mir, s0, s1, s2, s3));
    endtask

    task automatic sb_check();
        exp_t e;
        chk("a_addr_valid", 64'(a_avld), 64'(qa.size() > 0));
        if (qa.size() > 0) begin
            e = qa.pop_front();
            if (a_avld) begin
                chk("a_sg_addr", a_addr, e.addr);
                chk("a_sg_oob", 64'(a_oob), 64'(e.oob));
            end
        end
        chk("b_addr_valid", 64'(b_avld), 64'(qb.size() > 0));
        if (qb.size() > 0) begin
            e = qb.pop_front();
            if (b_avld) begin
                chk("b_sg_addr", b_addr, e.addr);
                chk("b_sg_oob", 64'(b_oob), 64'(e.oob));
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        sb_check();
    endtask

    task automatic chk_a_reset(input string tag);
        chk({tag, "_angle"}, 64'(a_angle), 64'h03020100);
        chk({tag, "_en"},    64'(a_en), 64'hF);
        chk({tag, "_has"},   64'(a_has), 64'd0);
        chk({tag, "_ack"},   64'(a_ack), 64'd0);
        chk({tag, "_busy"},  64'(a_busy), 64'd0);
        chk({tag, "_done"},  64'(a_done), 64'd0);
        chk({tag, "_addr"},  a_addr, 64'd0);
        chk({tag, "_oob"},   64'(a_oob), 64'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        a_start = 0; a_mirror = 0; a_sv = 0; a_next = 0; a_s = '0;
        b_start = 0; b_mirror = 0; b_sv = 0; b_next = 0; b_s = '0;
        a_g = 0; b_g = 0; a_mir = 0; b_mir = 0;
        tick();
        tick();
        chk_a_reset("reset");
        chk("reset_b_en", 64'(b_en), 64'hF);

        // IDLE ignores s_valid and next_angle
        reset_n = 1'b1;
        a_s = 32'h01020304; a_sv = 1'b1; a_next = 1'b1;
        tick();
        a_sv = 1'b0; a_next = 1'b0;
        chk("idle_busy", 64'(a_busy), 64'd0);
        chk("idle_done", 64'(a_done), 64'd0);

        // Test 1: start then first group addressing
        a_start = 1'b1; a_mirror = 1'b0;
        tick();
        a_start = 1'b0;
        chk("t1_busy", 64'(a_busy), 64'd1);
        chk("t1_has_next", 64'(a_has), 64'd1);
        drive_a(3, 2, 1, 0);
        tick();
        a_sv = 1'b0;
        chk("t1_addr", a_addr, {16'd771, 16'd514, 16'd257, 16'd0});
        chk("t1_angle", 64'(a_angle), 64'h03020100);
        chk("t1_en", 64'(a_en), 64'hF);

        // start during SWEEP must not relatch mirror
        a_start = 1'b1; a_mirror = 1'b1;
        tick();
        a_start = 1'b0; a_mirror = 1'b0;

        // Test 5: address together with an accepted advance uses the old group
        drive_a(0, 0, 0, 5);
        a_next = 1'b1;
        #1;
        chk("t5_ack", 64'(a_ack), 64'd1);
        tick();
        a_sv = 1'b0; a_next = 1'b0;
        a_g = 1;
        chk("t5_old_addr", 64'(a_addr[15:0]), 64'd5);
        chk("t5_angle", 64'(a_angle), 64'h07060504);
        drive_a(0, 0, 0, 5);
        tick();
        a_sv = 1'b0;
        chk("t5_new_addr", 64'(a_addr[15:0]), 64'd1029);

        // Test 2: stream back-to-back while advancing to the last group
        while (a_g < 44) begin
            drive_a(a_g % 7, 100, 255, a_g);
            a_next = 1'b1;
            #1;
            chk("t2_ack", 64'(a_ack), 64'd1);
            tick();
            a_g++;
        end
        a_sv = 1'b0; a_next = 1'b0;
        chk("t2_last_angle", 64'(a_angle), 64'hB3B2B1B0);
        chk("t2_last_has", 64'(a_has), 64'd0);
        chk("t2_last_en", 64'(a_en), 64'hF);
        drive_a(10, 20, 30, 40);
        a_next = 1'b1;
        #1;
        chk("t2_final_ack", 64'(a_ack), 64'd0);
        tick();
        a_sv = 1'b0; a_next = 1'b0;
        chk("t2_done", 64'(a_done), 64'd1);
        chk("t2_busy", 64'(a_busy), 64'd0);
        chk("t2_angle_rewind", 64'(a_angle), 64'h03020100);

        // Restart in the first IDLE cycle
        a_start = 1'b1; a_mirror = 1'b0;
        tick();
        a_start = 1'b0;
        a_g = 0;
        chk("restart_done", 64'(a_done), 64'd0);
        chk("restart_busy", 64'(a_busy), 64'd1);

        // Test 6: reset in group 10 with s_valid and next_angle pending
        while (a_g < 10) begin
            a_next = 1'b1;
            tick();
            a_g++;
        end
        a_next = 1'b0;
        chk("t6_angle_g10", 64'(a_angle), 64'h2B2A2928);
        a_s = 32'h04030201; a_sv = 1'b1; a_next = 1'b1;
        reset_n = 1'b0;
        tick();
        chk_a_reset("t6_rst");
        tick();
        chk("t6_done_hold", 64'(a_done), 64'd0);
        reset_n = 1'b1; a_sv = 1'b0; a_next = 1'b0;
        a_g = 0; a_mir = 0;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        chk("t6_restart_busy", 64'(a_busy), 64'd1);
        chk("t6_restart_angle", 64'(a_angle), 64'h03020100);
        drive_a(9, 8, 7, 6);
        tick();
        a_sv = 1'b0;

        // Test 4: mirror and out-of-range on the 9-bit-s instance
        b_start = 1'b1; b_mirror = 1'b1;
        tick();
        b_start = 1'b0; b_mirror = 1'b0;
        b_mir = 1; b_g = 0;
        drive_b(3, 2, 300, 0);
        tick();
        b_sv = 1'b0;
        chk("t4_mirror_addr", 64'(b_addr[15:0]), 64'd255);
        chk("t4_oob_addr", 64'(b_addr[31:16]), 64'd0);
        chk("t4_oob_flag", 64'(b_oob), 64'b0010);

        // Test 3: partial last group with 182 angles
        while (b_g < 45) begin
            b_next = 1'b1;
            #1;
            chk("t3_ack", 64'(b_ack), 64'd1);
            tick();
            b_g++;
        end
        b_next = 1'b0;
        chk("t3_angle_lo", 64'(b_angle[15:0]), 64'hB5B4);
        chk("t3_en", 64'(b_en), 64'b0011);
        chk("t3_has", 64'(b_has), 64'd0);
        drive_b(50, 40, 30, 20);
        tick();
        b_sv = 1'b0;
        chk("t3_upper_zero", 64'(b_addr[63:32]), 64'd0);
        b_next = 1'b1;
        tick();
        b_next = 1'b0;
        chk("t3_done", 64'(b_done), 64'd1);

        tick();
        chk("queues_empty", 64'(qa.size() + qb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", na, nf);
        $finish;
    end

endmodule
